alu_rs: RTL and testbench

Reservation station and issue scheduler for the scalar ALU. It buffers decoded ALU and branch-compare instructions and captures operand values from two result broadcast buses (ALU and LSB). Each cycle it issues at most one operand-ready entry to the scalar ALU over its valid/work_type/r1/r2/rob_id interface. It sits between the dispatcher and the scalar ALU, and is flushed by the ROB on misprediction.

---
 rtl/alu_rs_if.sv | 46 ++++
 rtl/alu_rs.sv | 127 ++++++++++++
 tb/tb_alu_rs.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and issue signals of the ALU reservation station.
// Dispatch is accepted at an edge where rdy_in & inst_valid & !full & !flush; issue is a one-cycle alu_valid strobe with no backpressure.
interface alu_rs_if #(
  parameter int TYPE_BIT = 6,
  parameter int ROB_BIT  = 4
);
  logic                inst_valid;
  logic [TYPE_BIT-1:0] inst_type;
  logic [ROB_BIT-1:0]  inst_rob_id;
  logic                inst_j_dep;
  logic [ROB_BIT-1:0]  inst_j_tag;
  logic [31:0]         inst_j_val;
  logic                inst_k_dep;
  logic [ROB_BIT-1:0]  inst_k_tag;
  logic [31:0]         inst_k_val;
  logic                full;

  logic                alu_bc_valid;
  logic [ROB_BIT-1:0]  alu_bc_rob_id;
  logic [31:0]         alu_bc_value;
  logic                lsb_bc_valid;
  logic [ROB_BIT-1:0]  lsb_bc_rob_id;
  logic [31:0]         lsb_bc_value;

  logic                alu_valid;
  logic [TYPE_BIT-1:0] alu_type;
  logic [31:0]         alu_r1;
  logic [31:0]         alu_r2;
  logic [ROB_BIT-1:0]  alu_rob_id;

  modport master (
    output inst_valid, inst_type, inst_rob_id, inst_j_dep, inst_j_tag, inst_j_val,
           inst_k_dep, inst_k_tag, inst_k_val,
           alu_bc_valid, alu_bc_rob_id, alu_bc_value,
           lsb_bc_valid, lsb_bc_rob_id, lsb_bc_value,
    input  full, alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id
  );

  modport slave (
    input  inst_valid, inst_type, inst_rob_id, inst_j_dep, inst_j_tag, inst_j_val,
           inst_k_dep, inst_k_tag, inst_k_val,
           alu_bc_valid, alu_bc_rob_id, alu_bc_value,
           lsb_bc_valid, lsb_bc_rob_id, lsb_bc_value,
    output full, alu_valid, alu_type, alu_r1, alu_r2, alu_rob_id
  );
endinterface

// File: rtl/alu_rs.sv
// Reservation station for the scalar ALU: buffers dispatched ops, captures operands
// from the ALU/LSB broadcast buses and issues the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int RS_SIZE  = 8,
  parameter int TYPE_BIT = 6,
  parameter int ROB_BIT  = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic flush,
  alu_rs_if.slave bus
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic                valid [RS_SIZE];
  logic [TYPE_BIT-1:0] op    [RS_SIZE];
  logic [ROB_BIT-1:0]  rob   [RS_SIZE];
  logic                j_dep [RS_SIZE];
  logic [ROB_BIT-1:0]  j_tag [RS_SIZE];
  logic [31:0]         j_val [RS_SIZE];
  logic                k_dep [RS_SIZE];
  logic [ROB_BIT-1:0]  k_tag [RS_SIZE];
  logic [31:0]         k_val [RS_SIZE];

  logic                has_free;
  logic [IDX_W-1:0]    free_idx;
  logic                has_cand;
  logic [IDX_W-1:0]    cand_idx;

  logic                abc_v, lbc_v;
  logic [ROB_BIT-1:0]  abc_tag, lbc_tag;
  logic [31:0]         abc_val, lbc_val;

  assign abc_v   = bus.alu_bc_valid;
  assign abc_tag = bus.alu_bc_rob_id;
  assign abc_val = bus.alu_bc_value;
  assign lbc_v   = bus.lsb_bc_valid;
  assign lbc_tag = bus.lsb_bc_rob_id;
  assign lbc_val = bus.lsb_bc_value;

  // Returns {dep, value} after snooping both buses; the ALU bus wins a tag tie.
  function automatic logic [32:0] capture(input logic dep, input logic [ROB_BIT-1:0] tag,
                                          input logic [31:0] val);
    logic [32:0] res;
    res = {dep, val};
    if (dep && abc_v && (tag == abc_tag))      res = {1'b0, abc_val};
    else if (dep && lbc_v && (tag == lbc_tag)) res = {1'b0, lbc_val};
    return res;
  endfunction

  // Both pickers scan downward so the lowest matching index wins.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    has_cand = 1'b0;
    cand_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (valid[i] && !j_dep[i] && !k_dep[i]) begin
        has_cand = 1'b1;
        cand_idx = IDX_W'(i);
      end
    end
  end

  assign bus.full = ~has_free;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        valid[i] <= 1'b0;
        op[i]    <= '0;
        rob[i]   <= '0;
        j_dep[i] <= 1'b0;
        j_tag[i] <= '0;
        j_val[i] <= '0;
        k_dep[i] <= 1'b0;
        k_tag[i] <= '0;
        k_val[i] <= '0;
      end
      bus.alu_valid  <= 1'b0;
      bus.alu_type   <= '0;
      bus.alu_r1     <= '0;
      bus.alu_r2     <= '0;
      bus.alu_rob_id <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < RS_SIZE; i++) valid[i] <= 1'b0;
        bus.alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (valid[i]) begin
            {j_dep[i], j_val[i]} <= capture(j_dep[i], j_tag[i], j_val[i]);
            {k_dep[i], k_val[i]} <= capture(k_dep[i], k_tag[i], k_val[i]);
          end
        end

        // Selection used pre-wakeup state, so a just-woken entry waits one cycle.
        if (has_cand) begin
          bus.alu_valid   <= 1'b1;
          bus.alu_type    <= op[cand_idx];
          bus.alu_r1      <= j_val[cand_idx];
          bus.alu_r2      <= k_val[cand_idx];
          bus.alu_rob_id  <= rob[cand_idx];
          valid[cand_idx] <= 1'b0;
        end else begin
          bus.alu_valid <= 1'b0;
        end

        // free_idx is always an invalid slot, so it never collides with cand_idx.
        if (bus.inst_valid && has_free) begin
          valid[free_idx] <= 1'b1;
          op[free_idx]    <= bus.inst_type;
          rob[free_idx]   <= bus.inst_rob_id;
          j_tag[free_idx] <= bus.inst_j_tag;
          k_tag[free_idx] <= bus.inst_k_tag;
          {j_dep[free_idx], j_val[free_idx]} <= capture(bus.inst_j_dep, bus.inst_j_tag, bus.inst_j_val);
          {k_dep[free_idx], k_val[free_idx]} <= capture(bus.inst_k_dep, bus.inst_k_tag, bus.inst_k_val);
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: dispatch, wakeup/forwarding, issue order, stall and flush.
module tb_alu_rs;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_q[$];

  alu_rs_if #(.TYPE_BIT(6), .ROB_BIT(4)) bus ();

  alu_rs #(.RS_SIZE(8), .TYPE_BIT(6), .ROB_BIT(4)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Outputs are read 1ns after the edge they were updated on.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.inst_valid    = 1'b0;
    bus.inst_type     = '0;
    bus.inst_rob_id   = '0;
    bus.inst_j_dep    = 1'b0;
    bus.inst_j_tag    = '0;
    bus.inst_j_val    = '0;
    bus.inst_k_dep    = 1'b0;
    bus.inst_k_tag    = '0;
    bus.inst_k_val    = '0;
    bus.alu_bc_valid  = 1'b0;
    bus.alu_bc_rob_id = '0;
    bus.alu_bc_value  = '0;
    bus.lsb_bc_valid  = 1'b0;
    bus.lsb_bc_rob_id = '0;
    bus.lsb_bc_value  = '0;
  endtask

  task automatic enq(input logic [5:0] t, input logic [3:0] r,
                     input logic jd, input logic [3:0] jt, input logic [31:0] jv,
                     input logic kd, input logic [3:0] kt, input logic [31:0] kv);
    bus.inst_valid  = 1'b1;
    bus.inst_type   = t;
    bus.inst_rob_id = r;
    bus.inst_j_dep  = jd;
    bus.inst_j_tag  = jt;
    bus.inst_j_val  = jv;
    bus.inst_k_dep  = kd;
    bus.inst_k_tag  = kt;
    bus.inst_k_val  = kv;
  endtask

  task automatic alu_bc(input logic [3:0] r, input logic [31:0] v);
    bus.alu_bc_valid  = 1'b1;
    bus.alu_bc_rob_id = r;
    bus.alu_bc_value  = v;
  endtask

  task automatic lsb_bc(input logic [3:0] r, input logic [31:0] v);
    bus.lsb_bc_valid  = 1'b1;
    bus.lsb_bc_rob_id = r;
    bus.lsb_bc_value  = v;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset then idle
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_valid", bus.alu_valid, 0);
      check_eq("idle_full", bus.full, 0);
    end
    check_eq("idle_type", bus.alu_type, 0);
    check_eq("idle_r1", bus.alu_r1, 0);
    check_eq("idle_r2", bus.alu_r2, 0);
    check_eq("idle_rob", bus.alu_rob_id, 0);

    // ADD with both operands ready
    enq(6'b000000, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
    tick(); clear_inputs();
    check_eq("add_t_valid", bus.alu_valid, 0);
    tick();
    check_eq("add_valid", bus.alu_valid, 1);
    check_eq("add_r1", bus.alu_r1, 5);
    check_eq("add_r2", bus.alu_r2, 7);
    check_eq("add_rob", bus.alu_rob_id, 3);
    check_eq("add_type", bus.alu_type, 6'b000000);
    tick();
    check_eq("add_after_valid", bus.alu_valid, 0);
    check_eq("add_hold_r1", bus.alu_r1, 5);

    // SUB waiting on rob 2, woken by the ALU bus at t+3
    enq(6'b001000, 4'd4, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd1);
    tick(); clear_inputs();
    tick(); check_eq("sub_t1_valid", bus.alu_valid, 0);
    tick(); check_eq("sub_t2_valid", bus.alu_valid, 0);
    alu_bc(4'd2, 32'd10);
    tick(); clear_inputs();
    check_eq("sub_t3_valid", bus.alu_valid, 0);
    tick();
    check_eq("sub_valid", bus.alu_valid, 1);
    check_eq("sub_r1", bus.alu_r1, 10);
    check_eq("sub_r2", bus.alu_r2, 1);
    check_eq("sub_type", bus.alu_type, 6'b001000);
    check_eq("sub_rob", bus.alu_rob_id, 4);

    // broadcast in the enqueue cycle is forwarded
    enq(6'b001000, 4'd5, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd1);
    alu_bc(4'd2, 32'd11);
    tick(); clear_inputs();
    tick();
    check_eq("fwd_valid", bus.alu_valid, 1);
    check_eq("fwd_rob", bus.alu_rob_id, 5);
    check_eq("fwd_r1", bus.alu_r1, 11);

    // ALU bus beats LSB bus on the same tag
    enq(6'b000000, 4'd6, 1'b0, 4'd0, 32'd3, 1'b1, 4'd6, 32'd0);
    alu_bc(4'd6, 32'd100);
    lsb_bc(4'd6, 32'd200);
    tick(); clear_inputs();
    tick();
    check_eq("prio_valid", bus.alu_valid, 1);
    check_eq("prio_rob", bus.alu_rob_id, 6);
    check_eq("prio_r2", bus.alu_r2, 100);
    tick();
    check_eq("prio_after_valid", bus.alu_valid, 0);

    // fill all 8 entries; entries 2 and 5 wait on tag 12, the rest on 15
    for (int i = 0; i < 8; i++) begin
      enq(6'b000000, 4'(i), 1'b1, (i == 2 || i == 5) ? 4'd12 : 4'd15, 32'd0,
          1'b0, 4'd0, 32'(i * 3));
      tick();
      check_eq("fill_full", bus.full, (i == 7) ? 1 : 0);
    end
    enq(6'b000000, 4'd9, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
    tick(); clear_inputs();
    check_eq("ninth_full", bus.full, 1);
    check_eq("ninth_valid", bus.alu_valid, 0);

    exp_q.push_back(32'd2);
    exp_q.push_back(32'd5);
    lsb_bc(4'd12, 32'h55);
    tick(); clear_inputs();
    check_eq("wake_edge_valid", bus.alu_valid, 0);
    tick();
    check_eq("wake_first_valid", bus.alu_valid, 1);
    check_eq("wake_first_r1", bus.alu_r1, 32'h55);
    for (int i = 0; i < 4; i++) begin
      if (bus.alu_valid) begin
        if (exp_q.size() > 0) check_eq("wake_order", bus.alu_rob_id, exp_q.pop_front());
        else check_eq("wake_extra_issue", bus.alu_valid, 0);
      end
      tick();
    end
    check_eq("wake_drained", exp_q.size(), 0);
    check_eq("wake_full_after", bus.full, 0);

    flush = 1'b1;
    tick(); flush = 1'b0;
    check_eq("fill_flush_full", bus.full, 0);

    // rdy_in low freezes an issued entry and ignores inputs
    enq(6'b100001, 4'd7, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22);
    tick();
    enq(6'b000000, 4'd8, 1'b0, 4'd0, 32'h33, 1'b0, 4'd0, 32'h44);
    tick(); clear_inputs();
    check_eq("rdy_a_valid", bus.alu_valid, 1);
    check_eq("rdy_a_rob", bus.alu_rob_id, 7);
    check_eq("rdy_a_type", bus.alu_type, 6'b100001);
    rdy = 1'b0;
    enq(6'b000000, 4'd10, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
    alu_bc(4'd15, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_valid", bus.alu_valid, 1);
      check_eq("stall_rob", bus.alu_rob_id, 7);
      check_eq("stall_r1", bus.alu_r1, 32'h11);
    end
    clear_inputs();
    rdy = 1'b1;
    tick();
    check_eq("resume_valid", bus.alu_valid, 1);
    check_eq("resume_rob", bus.alu_rob_id, 8);
    check_eq("resume_r2", bus.alu_r2, 32'h44);
    tick();
    check_eq("resume_after_valid", bus.alu_valid, 0);
    tick();
    check_eq("stall_enq_ignored", bus.alu_valid, 0);

    // flush with 4 entries, 2 of them ready, plus a concurrent enqueue
    enq(6'b000000, 4'd1, 1'b1, 4'd13, 32'd0, 1'b0, 4'd0, 32'd0); tick();
    enq(6'b000000, 4'd2, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd0); tick();
    enq(6'b000000, 4'd3, 1'b1, 4'd13, 32'd0, 1'b0, 4'd0, 32'd0); tick();
    enq(6'b000000, 4'd4, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd0); tick();
    clear_inputs();
    alu_bc(4'd13, 32'h99);
    tick(); clear_inputs();
    check_eq("pre_flush_valid", bus.alu_valid, 0);
    flush = 1'b1;
    enq(6'b000000, 4'd6, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
    lsb_bc(4'd14, 32'h77);
    tick(); clear_inputs(); flush = 1'b0;
    check_eq("flush_valid", bus.alu_valid, 0);
    check_eq("flush_full", bus.full, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("flush_no_issue", bus.alu_valid, 0);
    end

    // still operational after flush
    enq(6'b000010, 4'd9, 1'b0, 4'd0, 32'hA, 1'b0, 4'd0, 32'hB);
    tick(); clear_inputs();
    tick();
    check_eq("post_valid", bus.alu_valid, 1);
    check_eq("post_rob", bus.alu_rob_id, 9);
    check_eq("post_r1", bus.alu_r1, 32'hA);
    check_eq("post_type", bus.alu_type, 6'b000010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
